// File: rtl/salamander_ioctl_loader_if.sv
// Bundles the ioctl byte-download bus and the SDRAM write-request channel.
// The master modport is the loader's view; the slave modport is the transmitter/arbiter view.
interface salamander_ioctl_loader_if;
  logic        ioctl_download;
  logic [15:0] ioctl_index;
  logic [26:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic        ioctl_wait;
  logic [21:0] o_SDRAM_ADDR;
  logic [15:0] o_SDRAM_DATA;
  logic [1:0]  o_SDRAM_BE;
  logic        o_SDRAM_WR_REQ;
  logic        i_SDRAM_WR_ACK;

  modport master (
    input  ioctl_download, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr, i_SDRAM_WR_ACK,
    output ioctl_wait, o_SDRAM_ADDR, o_SDRAM_DATA, o_SDRAM_BE, o_SDRAM_WR_REQ
  );

  modport slave (
    output ioctl_download, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr, i_SDRAM_WR_ACK,
    input  ioctl_wait, o_SDRAM_ADDR, o_SDRAM_DATA, o_SDRAM_BE, o_SDRAM_WR_REQ
  );
endinterface

// File: rtl/salamander_ioctl_loader.sv
// Packs ioctl download bytes into 16-bit SDRAM words, issuing one held write request per word
// and flushing a lone trailing even byte when the download ends.
module salamander_ioctl_loader #(
  parameter logic [15:0] ROM_INDEX = 16'h0000
) (
  input  logic                             i_EMU_MCLK,
  input  logic                             i_EMU_INITRST,
  salamander_ioctl_loader_if.master        bus,
  output logic [21:0]                      o_WORD_CNT,
  output logic                             o_ROM_DOWNLOAD_DONE,
  output logic                             o_OVERRUN
);

  typedef enum logic [2:0] {IDLE, COLLECT, REQ, FLUSH, DONE} state_t;

  state_t      state, state_n;
  logic [7:0]  pend_data, pend_data_n;
  logic [21:0] pend_addr, pend_addr_n;
  logic        pend_valid, pend_valid_n;
  logic [21:0] req_addr, req_addr_n;
  logic [15:0] req_data, req_data_n;
  logic [1:0]  req_be, req_be_n;
  logic [21:0] word_cnt, word_cnt_n;
  logic        done, done_n;
  logic        overrun, overrun_n;
  logic        dl_low_q;
  logic        hit_q;

  logic        index_match, hit, start, accept, busy, odd;
  logic [21:0] waddr;
  logic [3:0]  unused_addr_hi;

  assign index_match    = (bus.ioctl_index == ROM_INDEX);
  assign busy           = (state == REQ) || (state == FLUSH);
  assign hit            = bus.ioctl_download && bus.ioctl_wr && index_match;
  // dl_low_q resets to 0 so a download already active at reset release never looks like a rising edge
  assign start          = bus.ioctl_download && dl_low_q && index_match;
  assign accept         = (state == COLLECT) && hit && !hit_q;
  assign waddr          = bus.ioctl_addr[22:1];
  assign odd            = bus.ioctl_addr[0];
  assign unused_addr_hi = bus.ioctl_addr[26:23];

  always_comb begin
    state_n      = state;
    pend_data_n  = pend_data;
    pend_addr_n  = pend_addr;
    pend_valid_n = pend_valid;
    req_addr_n   = req_addr;
    req_data_n   = req_data;
    req_be_n     = req_be;
    word_cnt_n   = word_cnt;
    done_n       = done;
    overrun_n    = overrun;

    // A strobe during a pending request, or one cycle after the previous strobe, breaks the spacing contract
    if (hit && (busy || hit_q))
      overrun_n = 1'b1;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n      = COLLECT;
          word_cnt_n   = '0;
          done_n       = 1'b0;
          overrun_n    = 1'b0;
          pend_valid_n = 1'b0;
        end
      end
      COLLECT: begin
        if (!bus.ioctl_download) begin
          if (pend_valid) begin
            req_addr_n   = pend_addr;
            req_data_n   = {8'h00, pend_data};
            req_be_n     = 2'b01;
            pend_valid_n = 1'b0;
            state_n      = FLUSH;
          end else begin
            done_n  = 1'b1;
            state_n = DONE;
          end
        end else if (accept) begin
          if (!odd) begin
            if (pend_valid && (pend_addr != waddr)) begin
              req_addr_n = pend_addr;
              req_data_n = {8'h00, pend_data};
              req_be_n   = 2'b01;
              state_n    = REQ;
            end
            pend_data_n  = bus.ioctl_data;
            pend_addr_n  = waddr;
            pend_valid_n = 1'b1;
          end else if (pend_valid && (pend_addr == waddr)) begin
            req_addr_n   = waddr;
            req_data_n   = {bus.ioctl_data, pend_data};
            req_be_n     = 2'b11;
            pend_valid_n = 1'b0;
            state_n      = REQ;
          end else begin
            req_addr_n = waddr;
            req_data_n = {bus.ioctl_data, 8'h00};
            req_be_n   = 2'b10;
            state_n    = REQ;
          end
        end
      end
      REQ: begin
        if (bus.i_SDRAM_WR_ACK) begin
          word_cnt_n = word_cnt + 22'd1;
          state_n    = COLLECT;
        end
      end
      FLUSH: begin
        if (bus.i_SDRAM_WR_ACK) begin
          word_cnt_n = word_cnt + 22'd1;
          done_n     = 1'b1;
          state_n    = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
    if (i_EMU_INITRST) begin
      state      <= IDLE;
      pend_data  <= '0;
      pend_addr  <= '0;
      pend_valid <= 1'b0;
      req_addr   <= '0;
      req_data   <= '0;
      req_be     <= '0;
      word_cnt   <= '0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      dl_low_q   <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      state      <= state_n;
      pend_data  <= pend_data_n;
      pend_addr  <= pend_addr_n;
      pend_valid <= pend_valid_n;
      req_addr   <= req_addr_n;
      req_data   <= req_data_n;
      req_be     <= req_be_n;
      word_cnt   <= word_cnt_n;
      done       <= done_n;
      overrun    <= overrun_n;
      dl_low_q   <= !bus.ioctl_download;
      hit_q      <= hit;
    end
  end

  assign bus.ioctl_wait      = busy;
  assign bus.o_SDRAM_WR_REQ  = busy;
  assign bus.o_SDRAM_ADDR    = req_addr;
  assign bus.o_SDRAM_DATA    = req_data;
  assign bus.o_SDRAM_BE      = req_be;
  assign o_WORD_CNT          = word_cnt;
  assign o_ROM_DOWNLOAD_DONE = done;
  assign o_OVERRUN           = overrun;

endmodule

// File: doc/salamander_ioctl_loader.md
SALAMANDER_IOCTL_LOADER -- requirements
Module: salamander_ioctl_loader

Interface
REQ-001 The block SHALL have parameter ROM_INDEX, default 16'h0000: the ioctl_index value that selects this loader.
REQ-002 The block SHALL have port i_EMU_MCLK, input, 1 bit: the single 72 MHz master clock; all logic is on its rising edge.
REQ-003 The block SHALL have port i_EMU_INITRST, input, 1 bit: asynchronous active-high reset.
REQ-004 The block SHALL have port ioctl_download, input, 1 bit: a download is in progress.
REQ-005 The block SHALL have port ioctl_index, input, 16 bits: the download target selector.
REQ-006 The block SHALL have port ioctl_addr, input, 27 bits: the byte address.
REQ-007 The block SHALL have port ioctl_data, input, 8 bits: the byte data.
REQ-008 The block SHALL have port ioctl_wr, input, 1 bit: a single-cycle byte strobe.
REQ-009 The block SHALL have port ioctl_wait, output, 1 bit: the transmitter must hold off the next strobe while high.
REQ-010 The block SHALL have port o_SDRAM_ADDR, output, 22 bits: the SDRAM word address.
REQ-011 The block SHALL have port o_SDRAM_DATA, output, 16 bits: the write word; even byte in [7:0], odd byte in [15:8].
REQ-012 The block SHALL have port o_SDRAM_BE, output, 2 bits: byte enables; bit0 = [7:0], bit1 = [15:8].
REQ-013 The block SHALL have port o_SDRAM_WR_REQ, output, 1 bit: write request, level-held until acknowledged.
REQ-014 The block SHALL have port i_SDRAM_WR_ACK, input, 1 bit: single-cycle acknowledge from the SDRAM arbiter.
REQ-015 The block SHALL have port o_WORD_CNT, output, 22 bits: number of acknowledged writes in the current download.
REQ-016 The block SHALL have port o_ROM_DOWNLOAD_DONE, output, 1 bit: sticky completion flag.
REQ-017 The block SHALL have port o_OVERRUN, output, 1 bit: sticky flag, set when a strobe arrives while ioctl_wait is high.

Function
REQ-018 The block SHALL accept a byte when ioctl_download=1, ioctl_wr=1, ioctl_index=ROM_INDEX and ioctl_wait=0; all other strobes SHALL be ignored.
REQ-019 The state machine SHALL have states IDLE, COLLECT, REQ, FLUSH and DONE.
REQ-020 In IDLE, when ioctl_download rises with a matching index, the block SHALL clear o_WORD_CNT and o_ROM_DOWNLOAD_DONE and go to COLLECT.
REQ-021 In COLLECT, an accepted even-address byte SHALL be latched into pending[7:0] with its word address ioctl_addr[22:1], and pending-valid SHALL be set; no request is issued.
REQ-022 In COLLECT, an accepted odd byte whose word address matches the pending word SHALL issue a request with {odd,pending} and BE=2'b11, and SHALL clear pending-valid.
REQ-023 In COLLECT, an accepted odd byte with no matching pending word SHALL issue a request with data {odd,8'h00} and BE=2'b10.
REQ-024 In COLLECT, an accepted even byte while pending-valid=1 with a different word address SHALL issue a request for the old pending word with BE=2'b01, and the new byte SHALL become the pending word in the same cycle.
REQ-025 The request outputs (o_SDRAM_ADDR, o_SDRAM_DATA, o_SDRAM_BE) SHALL be registered from dedicated request registers, separate from the pending registers.
REQ-026 o_SDRAM_WR_REQ and ioctl_wait SHALL both rise on the cycle after the triggering strobe (state REQ), and address, data and BE SHALL be held stable while the request is high.
REQ-027 When i_SDRAM_WR_ACK=1 is sampled in REQ, the block SHALL drop o_SDRAM_WR_REQ and ioctl_wait on the next cycle, increment o_WORD_CNT (wrapping at 2^22), and return to COLLECT.
REQ-028 An ack that arrives while o_SDRAM_WR_REQ=0 SHALL be ignored.
REQ-029 A strobe seen while ioctl_wait=1 SHALL be dropped and SHALL set o_OVERRUN.
REQ-030 When ioctl_download falls in COLLECT or REQ, any outstanding request SHALL complete first.
REQ-031 After the download fall, if pending-valid=1 the block SHALL enter FLUSH and issue a request with BE=2'b01 and data {8'h00,pending}, with ioctl_wait held high through the flush; otherwise it SHALL go directly to DONE.
REQ-032 In DONE, o_ROM_DOWNLOAD_DONE SHALL be 1 and ioctl_wait 0.
REQ-033 DONE SHALL return to IDLE behaviour on the next matching rising edge of ioctl_download, which clears DONE, o_WORD_CNT and o_OVERRUN.
REQ-034 The transmitter contract SHALL be a minimum strobe spacing of 2 cycles; a back-to-back strobe SHALL be treated as an overrun.

Reset
REQ-035 While i_EMU_INITRST=1, the state SHALL be IDLE and every output and internal register SHALL be 0; this applies immediately and asynchronously, including mid-request.
REQ-036 After reset release, the block SHALL wait for a fresh rising edge of ioctl_download; a download already active at release SHALL be ignored until it falls.

Verification
REQ-037 After reset, bytes 11,22,33,44 at addresses 0-3 with ack after 1 cycle -> requests (addr 0, data 2211, BE 11) then (addr 1, data 4433, BE 11); o_WORD_CNT=2; o_ROM_DOWNLOAD_DONE=1 after ioctl_download falls.
REQ-038 Ack delayed 10 cycles -> ioctl_wait and o_SDRAM_WR_REQ high for 11 cycles with addr, data and BE unchanged; o_OVERRUN=0.
REQ-039 Three bytes AA,BB,CC at addresses 0-2, then download falls -> flush request (addr 1, data 00CC, BE 01); DONE=1 only after that ack.
REQ-040 ioctl_index=1 with ROM_INDEX=0 and 8 strobes -> no request, ioctl_wait stays 0, o_WORD_CNT=0, DONE stays 0.
REQ-041 Even byte 55 at address 4, then even byte 66 at address 8 -> request (addr 2, data 0055, BE 01); a later odd byte 77 at address 9 -> request (addr 4, data 7766, BE 11).
REQ-042 i_EMU_INITRST asserted while o_SDRAM_WR_REQ=1 -> o_SDRAM_WR_REQ, ioctl_wait and o_WORD_CNT are 0 with no clock edge; download ignored until its next rising edge.
